// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;
  localparam int SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_0   = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1   = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2   = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3   = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4   = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5   = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6   = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7   = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8   = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9   = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A   = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B   = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C   = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D   = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E   = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F   = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Display snapshot captured on load.
  typedef struct packed {
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits;
    logic [NUM_DIGITS-1:0]              dp;
  } snap_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host-side load bus and LED-board drive lines of the scan driver.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic                          load;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in;
  logic [NUM_DIGITS-1:0]         dp_in;
  logic                          blank_lz;
  logic [NUM_DIGITS-1:0]         an;
  logic [SEG_W-1:0]              seg;
  logic                          dp;

  modport master (
    output load, digits_in, dp_in, blank_lz,
    input  an, seg, dp
  );

  modport slave (
    input  load, digits_in, dp_in, blank_lz,
    output an, seg, dp
  );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational nibble to active-low 7-segment lookup; 10-15 render as hex.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_nib,
  output logic [SEG_W-1:0]   o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_nib)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode driver: snapshot on load, one digit
// per slot with a dark guard interval at slot start and leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GRD  = CNT_W'(GUARD_CYCLES);

  snap_t             r_snap;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  scan_state_t       r_state;
  logic [NUM_DIGITS-1:0] r_an;
  logic [SEG_W-1:0]  r_seg;
  logic              r_dp;

  logic                              w_wrap;
  logic [CNT_W-1:0]                  w_cnt_nxt;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]  w_seg_lane;
  logic [NUM_DIGITS-1:0]             w_zero;
  logic [NUM_DIGITS-1:0]             w_hi_zero;
  logic [NUM_DIGITS-1:0]             w_blank;

  // Every digit is decoded in parallel; the scan index just picks a lane.
  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_lane
      seg7_decoder u_dec (
        .i_nib (r_snap.digits[g]),
        .o_seg (w_seg_lane[g])
      );
      assign w_zero[g] = (r_snap.digits[g] == '0);
    end
  endgenerate

  // w_hi_zero[i]: digit i and everything above it are zero.
  always_comb begin
    w_hi_zero = '0;
    w_blank   = '0;
    w_hi_zero[NUM_DIGITS-1] = w_zero[NUM_DIGITS-1];
    for (int i = NUM_DIGITS - 2; i >= 0; i--)
      w_hi_zero[i] = w_zero[i] & w_hi_zero[i+1];
    for (int i = 1; i < NUM_DIGITS; i++)
      w_blank[i] = bus.blank_lz & w_hi_zero[i];
  end

  assign w_wrap    = (r_cnt == CNT_LAST);
  assign w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap <= '0;
    end else if (bus.load) begin
      r_snap.digits <= bus.digits_in;
      r_snap.dp     <= bus.dp_in;
    end
  end

  // State tracks the counter that it will hold after this edge, so it
  // always agrees with r_cnt: GUARD for the first GUARD_CYCLES counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= GUARD;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_wrap)
        r_idx <= r_idx + 1'b1;
      case (r_state)
        GUARD:   if (w_cnt_nxt >= CNT_GRD) r_state <= SHOW;
        SHOW:    if (w_wrap)               r_state <= GUARD;
        default:                           r_state <= GUARD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= '1;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else if (r_state == SHOW && !w_blank[r_idx]) begin
      r_an  <= ~(NUM_DIGITS'(1) << r_idx);
      r_seg <= w_seg_lane[r_idx];
      r_dp  <= ~r_snap.dp[r_idx];
    end else begin
      r_an  <= '1;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 4-cycle slot and 1-cycle guard.
module tb_seg7_scan_driver;

  logic clk;
  logic rst;
  int   k;
  int   n_chk;
  int   n_err;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(.REFRESH_DIV(4), .GUARD_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-written active-low codes for 0..F.
  logic [6:0] segt [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  // Expected digits for 32'h00001230 with blanking on.
  logic [7:0] lz_an  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [6:0] lz_seg [8] = '{7'h40, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // One rising edge, then land on the following falling edge.
  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic go(input int target);
    while (k < target) step();
  endtask

  initial begin
    n_chk = 0; n_err = 0; k = 0;
    rst = 1'b1;
    bus.load = 1'b1; bus.digits_in = 32'h0000_0007; bus.dp_in = 8'h01; bus.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an",  bus.an, 8'hFF);
    chk("rst_seg", {1'b0, bus.seg}, 8'h7F);
    chk("rst_dp",  {7'b0, bus.dp}, 8'h01);

    rst = 1'b0; bus.load = 1'b0; k = 0;
    go(1);  chk("rel_guard_an", bus.an, 8'hFF);
    go(2);  chk("rel_d0_an",  bus.an, 8'hFE);
            chk("rel_d0_seg", {1'b0, bus.seg}, 8'h40);
            chk("rel_d0_dp",  {7'b0, bus.dp}, 8'h01);

    // Scan order and timing
    bus.digits_in = 32'h8765_4321; bus.load = 1'b1;
    go(3);  bus.load = 1'b0;
    go(4);  chk("scan_d0_an",  bus.an, 8'hFE);
            chk("scan_d0_seg", {1'b0, bus.seg}, 8'h79);
    for (int d = 1; d < 8; d++) begin
      go(4*d + 1);
      chk($sformatf("scan_guard%0d_an", d), bus.an, 8'hFF);
      go(4*d + 3);
      chk($sformatf("scan_d%0d_an", d),  bus.an, ~(8'h01 << d));
      chk($sformatf("scan_d%0d_seg", d), {1'b0, bus.seg}, {1'b0, segt[d+1]});
    end
    go(34); chk("wrap_d0_an", bus.an, 8'hFE);
            chk("wrap_d0_seg", {1'b0, bus.seg}, 8'h79);

    // Leading-zero blanking, plus load-to-output latency on digit 0
    bus.digits_in = 32'h0000_1230; bus.blank_lz = 1'b1; bus.load = 1'b1;
    go(35); chk("lz_old_seg", {1'b0, bus.seg}, 8'h79);
            bus.load = 1'b0;
    go(36); chk("lz_new_seg", {1'b0, bus.seg}, 8'h40);
    for (int d = 1; d < 8; d++) begin
      go(35 + 4*d);
      chk($sformatf("lz_d%0d_an", d),  bus.an, lz_an[d]);
      chk($sformatf("lz_d%0d_seg", d), {1'b0, bus.seg}, {1'b0, lz_seg[d]});
    end
    go(67); chk("lz_d0_an", bus.an, lz_an[0]);
            chk("lz_d0_seg", {1'b0, bus.seg}, {1'b0, lz_seg[0]});

    // All-zero value with blanking: only digit 0 lit
    bus.digits_in = 32'h0; bus.load = 1'b1;
    go(68); bus.load = 1'b0;
    for (int d = 0; d < 8; d++) begin
      go(99 + 4*d);
      chk($sformatf("zero_d%0d_an", d),  bus.an, (d == 0) ? 8'hFE : 8'hFF);
      chk($sformatf("zero_d%0d_seg", d), {1'b0, bus.seg}, (d == 0) ? 8'h40 : 8'h7F);
    end

    // blank_lz is live, not latched; hex digit with decimal point
    bus.blank_lz = 1'b0; bus.digits_in = 32'h0000_000A; bus.dp_in = 8'h01; bus.load = 1'b1;
    go(128); bus.load = 1'b0;
             chk("live_lz_d7_an", bus.an, 8'h7F);
    go(131); chk("hex_d0_an",  bus.an, 8'hFE);
             chk("hex_d0_seg", {1'b0, bus.seg}, 8'h08);
             chk("hex_d0_dp",  {7'b0, bus.dp}, 8'h00);
    go(135); chk("hex_d1_an",  bus.an, 8'hFD);
             chk("hex_d1_seg", {1'b0, bus.seg}, 8'h40);
             chk("hex_d1_dp",  {7'b0, bus.dp}, 8'h01);

    // Load mid-slot on digit 2
    go(137); bus.digits_in = 32'h0000_0900; bus.load = 1'b1;
    go(138); chk("mid_old_an",  bus.an, 8'hFB);
             chk("mid_old_seg", {1'b0, bus.seg}, 8'h40);
             bus.load = 1'b0;
    go(139); chk("mid_new_seg", {1'b0, bus.seg}, 8'h10);
    go(140); chk("mid_hold_an", bus.an, 8'hFB);
    go(141); chk("mid_guard_an", bus.an, 8'hFF);

    // Reset mid-scan while digit 5 is shown
    go(150); chk("pre_rst_d5_an", bus.an, 8'hDF);
    rst = 1'b1;
    step();
    chk("mrst_an",  bus.an, 8'hFF);
    chk("mrst_seg", {1'b0, bus.seg}, 8'h7F);
    chk("mrst_dp",  {7'b0, bus.dp}, 8'h01);
    rst = 1'b0; k = 0;
    go(1); chk("mrst_guard_an", bus.an, 8'hFF);
    go(2); chk("mrst_d0_an",  bus.an, 8'hFE);
           chk("mrst_d0_seg", {1'b0, bus.seg}, 8'h40);
           chk("mrst_d0_dp",  {7'b0, bus.dp}, 8'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
